// File: rtl/halt_controller_pkg.sv
// halt_controller_pkg: shared state encoding and helpers for the halt controller.
//   HALT_ST_*      2-bit debug encodings of the FSM states
//   halt_state_e   FSM state type (2'b11 is unreachable and recovers to RUN)
//   in_kill_window true while a flush may still abort a halt in progress
package halt_controller_pkg;

  localparam logic [1:0] HALT_ST_RUN    = 2'b00;
  localparam logic [1:0] HALT_ST_DRAIN  = 2'b01;
  localparam logic [1:0] HALT_ST_HALTED = 2'b10;

  localparam int unsigned DrainCntW = 4;

  typedef enum logic [1:0] {
    HaltRun    = HALT_ST_RUN,
    HaltDrain  = HALT_ST_DRAIN,
    HaltHalted = HALT_ST_HALTED,
    HaltBad    = 2'b11
  } halt_state_e;

  // The drain counter runs down from drain_cycles-1, so the number of DRAIN cycles
  // already spent is drain_cycles-1-cnt. A branch resolving during the first
  // kill_cycles of them sits behind the ebreak and must cancel the halt.
  function automatic logic in_kill_window(input int unsigned drain_cycles,
                                          input int unsigned kill_cycles,
                                          input logic [DrainCntW-1:0] cnt);
    int elapsed;
    elapsed = int'(drain_cycles) - 1 - int'(cnt);
    return elapsed < int'(kill_cycles);
  endfunction

endpackage

// File: rtl/halt_drain_counter.sv
// halt_drain_counter: 4-bit loadable down-counter used to time the DRAIN phase.
//   clk      system clock, rising edge
//   rst      synchronous active-high reset, clears the count
//   load     load load_val (has priority over dec)
//   load_val value to load
//   dec      decrement; has no effect once the count is zero (never wraps)
//   count    current count
//   zero     count == 0
module halt_drain_counter
  import halt_controller_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [DrainCntW-1:0] load_val,
  input  logic                 dec,
  output logic [DrainCntW-1:0] count,
  output logic                 zero
);

  logic [DrainCntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign count = cnt_q;
  assign zero  = (cnt_q == '0);

endmodule

// File: rtl/halt_controller.sv
// halt_controller: sequences an orderly pipeline stop on an ebreak decoded in ID.
// Freezes fetch, squashes younger instructions, lets older ones drain through
// EX/MEM/WB, then reports halted. Its stall/flush outputs are ORed with the hazard
// unit's controls.
//
// Parameters:
//   DRAIN_CYCLES  cycles spent in DRAIN after acceptance (1..15)
//   KILL_CYCLES   leading DRAIN cycles in which flush aborts the halt (0..DRAIN_CYCLES)
// Build option:
//   HALT_RESUME_EN  when defined, resume in HALTED returns to RUN; otherwise the
//                   resume port is ignored and HALTED is terminal until rst.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   halt_req      ebreak decoded in ID
//   id_valid      ID-stage instruction is valid
//   flush         taken branch/jump flush from EX/MEM
//   resume        external resume pulse
//   pc_stall      hold PC
//   ifid_flush    zero IF/ID on next edge
//   idex_bubble   insert NOP into ID/EX in place of the ebreak
//   halted        pipeline drained and stopped
//   halt_state    current FSM state (debug)
module halt_controller
  import halt_controller_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned KILL_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       halt_req,
  input  logic       id_valid,
  input  logic       flush,
  input  logic       resume,
  output logic       pc_stall,
  output logic       ifid_flush,
  output logic       idex_bubble,
  output logic       halted,
  output logic [1:0] halt_state
);

`ifdef HALT_RESUME_EN
  localparam logic ResumeEn = 1'b1;
`else
  localparam logic ResumeEn = 1'b0;
`endif

  localparam logic [DrainCntW-1:0] DrainLoad = DrainCntW'(DRAIN_CYCLES - 1);

  halt_state_e          state;
  logic [DrainCntW-1:0] drain_cnt;
  logic                 cnt_zero;
  logic                 cnt_load;
  logic [DrainCntW-1:0] cnt_load_val;
  logic                 cnt_dec;

  logic accept;
  logic kill;
  logic drain_done;
  logic leave_halt;
  logic ctrl;

  always_comb begin
    accept     = (state == HaltRun) & halt_req & id_valid & ~flush;
    kill       = (state == HaltDrain) & flush &
                 in_kill_window(DRAIN_CYCLES, KILL_CYCLES, drain_cnt);
    drain_done = (state == HaltDrain) & cnt_zero & ~kill;
    // Gated by a constant rather than left unread so the port stays connected
    // in builds without the resume feature.
    leave_halt = (state == HaltHalted) & resume & ResumeEn;

    cnt_load     = accept | kill;
    cnt_load_val = accept ? DrainLoad : '0;
    cnt_dec      = (state == HaltDrain);
  end

  halt_drain_counter u_drain_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .count    (drain_cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HaltRun;
    end else begin
      unique case (state)
        HaltRun: begin
          if (accept) state <= HaltDrain;
        end
        HaltDrain: begin
          if (kill) begin
            state <= HaltRun;
          end else if (drain_done) begin
            state <= HaltHalted;
          end
        end
        HaltHalted: begin
          if (leave_halt) state <= HaltRun;
        end
        HaltBad: begin
          state <= HaltRun;
        end
        default: begin
          state <= HaltRun;
        end
      endcase
    end
  end

  // In RUN the controls follow accept combinationally so the ebreak itself is
  // replaced by a bubble in the same cycle it is seen.
  always_comb begin
    ctrl = 1'b0;
    unique case (state)
      HaltRun:    ctrl = accept;
      HaltDrain:  ctrl = 1'b1;
      HaltHalted: ctrl = 1'b1;
      HaltBad:    ctrl = 1'b0;
      default:    ctrl = 1'b0;
    endcase
  end

  assign pc_stall    = ctrl;
  assign ifid_flush  = ctrl;
  assign idex_bubble = ctrl;
  assign halted      = (state == HaltHalted);
  assign halt_state  = state;

endmodule

// File: tb/tb_halt_controller.sv
// Self-checking bench for halt_controller: directed scenarios followed by random
// stimulus, all compared each cycle against a cycle-count reference model.
module tb_halt_controller;

  localparam int unsigned D = 3;
  localparam int unsigned K = 1;

`ifdef HALT_RESUME_EN
  localparam bit ResumeOn = 1'b1;
`else
  localparam bit ResumeOn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, halt_req, id_valid, flush, resume;
  logic       pc_stall, ifid_flush, idex_bubble, halted;
  logic [1:0] halt_state;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0=run, 1=draining, 2=halted; k = DRAIN cycle number (1..D).
  int m_mode = 0;
  int m_k    = 0;

  always #5 clk = ~clk;

  halt_controller #(
    .DRAIN_CYCLES (D),
    .KILL_CYCLES  (K)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .halt_req    (halt_req),
    .id_valid    (id_valid),
    .flush       (flush),
    .resume      (resume),
    .pc_stall    (pc_stall),
    .ifid_flush  (ifid_flush),
    .idex_bubble (idex_bubble),
    .halted      (halted),
    .halt_state  (halt_state)
  );

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at posedge+1: drive inputs, check outputs mid-cycle, advance one edge,
  // then update the model with the inputs that edge sampled.
  task automatic step(input logic r, input logic hr, input logic iv, input logic fl,
                      input logic rs);
    logic acc, ctl;
    int   e_cnt;
    rst = r; halt_req = hr; id_valid = iv; flush = fl; resume = rs;
    #2;
    acc   = (m_mode == 0) && hr && iv && !fl;
    ctl   = (m_mode == 0) ? acc : 1'b1;
    e_cnt = (m_mode == 1) ? int'(D) - m_k : 0;
    check_eq("halt_state", 8'(halt_state), 8'(m_mode));
    check_eq("pc_stall", 8'(pc_stall), 8'(ctl));
    check_eq("ifid_flush", 8'(ifid_flush), 8'(ctl));
    check_eq("idex_bubble", 8'(idex_bubble), 8'(ctl));
    check_eq("halted", 8'(halted), 8'(m_mode == 2));
    check_eq("drain_cnt", 8'(dut.drain_cnt), 8'(e_cnt));
    @(posedge clk);
    #1;
    if (r) begin
      m_mode = 0; m_k = 0;
    end else begin
      case (m_mode)
        0: if (acc) begin m_mode = 1; m_k = 1; end
        1: begin
          if (fl && (m_k - 1) < int'(K)) begin m_mode = 0; m_k = 0; end
          else if (m_k == int'(D)) begin m_mode = 2; m_k = 0; end
          else m_k++;
        end
        default: if (ResumeOn && rs) m_mode = 0;
      endcase
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; halt_req = 1'b0; id_valid = 1'b0; flush = 1'b0; resume = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    check_eq("reset_state", 8'(halt_state), 8'h00);
    check_eq("reset_halted", 8'(halted), 8'h00);

    // Plain halt: accept then D drain cycles, halted on the D+1th edge.
    idle(4);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("drain_entry", 8'(halt_state), 8'h01);
    idle(3);
    check_eq("halt_latency", 8'(halted), 8'h01);
    idle(20);
    check_eq("halt_hold", 8'(halt_state), 8'h02);

    // Resume pulse; ignored unless the feature is built in. Then a second ebreak.
    idle(2);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("after_resume", 8'(halted), ResumeOn ? 8'h00 : 8'h01);
    idle(2);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(3);
    check_eq("second_halt", 8'(halted), 8'h01);

    // halt_req with flush in the same cycle is not accepted.
    do_reset();
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("req_flush", 8'(halt_state), 8'h00);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("req_novalid", 8'(halt_state), 8'h00);

    // Flush in the first DRAIN cycle aborts.
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("kill_abort", 8'(halt_state), 8'h00);
    idle(6);
    check_eq("kill_no_halt", 8'(halted), 8'h00);

    // Flush in the second DRAIN cycle is outside the window and ignored.
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    check_eq("late_flush", 8'(halted), 8'h01);

    // Reset mid-DRAIN.
    do_reset();
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1);
    do_reset();
    check_eq("rst_mid_drain", 8'(halt_state), 8'h00);
    idle(5);

    // Reset together with resume while halted: reset wins either way.
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(4);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("rst_vs_resume", 8'(halt_state), 8'h00);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 79) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 7) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
